// File: rtl/hex_word_tx_seq.sv
// Hex-string sequencer for the debug UART: prints a latched word MSB-nibble first as
// uppercase ASCII, with optional "0x" prefix and CR/LF suffix, on a valid/ready byte stream.
module hex_word_tx_seq #(
  parameter int NIBBLES = 8,
  parameter bit PREFIX  = 1'b1,
  parameter bit NEWLINE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   word,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT, CR, LF, FIN} state_t;

  localparam int         WW       = 4 * NIBBLES;
  localparam logic [3:0] LAST_NIB = 4'(NIBBLES - 1);

  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [3:0] sel_nibble(input logic [WW-1:0] w, input logic [3:0] idx);
    int unsigned     pos;
    logic [WW-1:0]   sh;
    pos = 4 * (NIBBLES - 1 - int'(idx));
    sh  = w >> pos;
    return sh[3:0];
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      nib_q, nib_d;
  logic [WW-1:0]   word_q, word_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            xfer;

  assign xfer = tx_valid_q && tx_ready;

  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = word;
          nib_d   = '0;
          state_d = PREFIX ? PFX0 : DIGIT;
        end
      end
      PFX0:  if (xfer) state_d = PFX1;
      PFX1:  if (xfer) state_d = DIGIT;
      DIGIT: begin
        if (xfer) begin
          if (nib_q == LAST_NIB) state_d = NEWLINE ? CR : FIN;
          else                   nib_d   = nib_q + 4'd1;
        end
      end
      CR:      if (xfer) state_d = LF;
      LF:      if (xfer) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the state being entered, so a stalled
    // character is simply recomputed from unchanged state and stays stable.
    tx_valid_d = (state_d == PFX0) || (state_d == PFX1) || (state_d == DIGIT) ||
                 (state_d == CR)   || (state_d == LF);
    busy_d     = tx_valid_d;
    done_d     = (state_d == FIN);
    case (state_d)
      PFX0:    tx_data_d = 8'h30;
      PFX1:    tx_data_d = 8'h78;
      DIGIT:   tx_data_d = hex2ascii(sel_nibble(word_d, nib_d));
      CR:      tx_data_d = 8'h0D;
      LF:      tx_data_d = 8'h0A;
      default: tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      nib_q      <= '0;
      word_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_hex_word_tx_seq.sv
// Directed bench for hex_word_tx_seq: scoreboard of expected characters plus cycle-exact
// checks of valid/busy/done, on a default instance and a 2-nibble bare instance.
module tb_hex_word_tx_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, tx_ready;
  logic [31:0] word;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;

  logic        start2, tx_ready2;
  logic [7:0]  word2;
  logic [7:0]  tx_data2;
  logic        tx_valid2, busy2, done2;

  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  logic [7:0]  exp_q[$];
  string       hexd = "0123456789ABCDEF";

  always #5 clk = ~clk;

  hex_word_tx_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word(word), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done)
  );

  hex_word_tx_seq #(.NIBBLES(2), .PREFIX(1'b0), .NEWLINE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .word(word2), .tx_ready(tx_ready2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
    for (int i = 7; i >= 0; i--) begin
      logic [3:0] n;
      n = w[4*i +: 4];
      exp_q.push_back(hexd[n]);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Scoreboard: every accepted character must be the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("extra_char", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else                   chk("char", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
    end
    if (done === 1'b1) done_cnt++;
  end

  // Start one string at edge 0 and check status cycle by cycle until after done.
  task automatic send(input logic [31:0] w, input int stall_at, input int stall_len,
                      input int exp_done, input logic [7:0] stall_char, input int poke_at);
    push_word(w);
    word = w; start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= exp_done + 1; c++) begin
      tx_ready = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
      if (poke_at > 0 && c == poke_at) begin start = 1'b1; word = 32'hFFFF_FFFF; end
      if (poke_at > 0 && c == poke_at + 1) start = 1'b0;
      @(negedge clk);
      if (c < exp_done) begin
        chk("valid_in_string", {31'h0, tx_valid}, 32'h1);
        chk("busy_in_string", {31'h0, busy}, 32'h1);
      end else if (c == exp_done) begin
        chk("done_pulse", {31'h0, done}, 32'h1);
        chk("busy_at_done", {31'h0, busy}, 32'h0);
        chk("valid_at_done", {31'h0, tx_valid}, 32'h0);
      end else begin
        chk("done_after", {31'h0, done}, 32'h0);
        chk("valid_idle", {31'h0, tx_valid}, 32'h0);
      end
      if (stall_len > 0 && c >= stall_at && c <= stall_at + stall_len)
        chk("stall_hold", {24'h0, tx_data}, {24'h0, stall_char});
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    chk("queue_empty", exp_q.size(), 32'h0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1; word = 32'h0;
    start2 = 1'b0; tx_ready2 = 1'b1; word2 = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_data", {24'h0, tx_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain string, then the same string with a 3-cycle stall on the third character.
    send(32'h1234ABCD, 0, 0, 13, 8'h00, 0);
    send(32'h1234ABCD, 3, 3, 16, 8'h31, 0);

    // Start and word change mid-string must be ignored.
    d0 = done_cnt;
    send(32'h1234ABCD, 0, 0, 13, 8'h00, 5);
    chk("one_done", done_cnt - d0, 32'h1);

    // Reset while the 6th character is offered.
    push_word(32'h1234ABCD);
    word = 32'h1234ABCD; start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("sixth_char", {24'h0, tx_data}, 32'h34);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'h0, tx_valid}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_data", {24'h0, tx_data}, 32'h0);
    chk("abandoned_chars", exp_q.size(), 32'h7);
    exp_q.delete();
    @(negedge clk);
    chk("midrst_no_done", {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    send(32'h0000_0000, 0, 0, 13, 8'h00, 0);

    // Bare 2-nibble instance.
    word2 = 8'hF0; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    @(negedge clk);
    chk("d2_c1_data", {24'h0, tx_data2}, 32'h46);
    chk("d2_c1_valid", {31'h0, tx_valid2}, 32'h1);
    @(negedge clk);
    chk("d2_c2_data", {24'h0, tx_data2}, 32'h30);
    chk("d2_c2_valid", {31'h0, tx_valid2}, 32'h1);
    @(negedge clk);
    chk("d2_c3_done", {31'h0, done2}, 32'h1);
    chk("d2_c3_valid", {31'h0, tx_valid2}, 32'h0);
    chk("d2_c3_busy", {31'h0, busy2}, 32'h0);
    @(posedge clk); #1;

    // Continuous start: period of 14 cycles (12 chars, done, one idle).
    push_word(32'h0F1E2D3C); push_word(32'h0F1E2D3C); push_word(32'h0F1E2D3C);
    word = 32'h0F1E2D3C; start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 42; c++) begin
      int p;
      if (c == 29) start = 1'b0;
      p = (c - 1) % 14;
      @(negedge clk);
      chk("bb_valid", {31'h0, tx_valid}, (p < 12) ? 32'h1 : 32'h0);
      chk("bb_done", {31'h0, done}, (p == 12) ? 32'h1 : 32'h0);
      if (p == 0) chk("bb_first", {24'h0, tx_data}, 32'h30);
      @(posedge clk); #1;
    end
    chk("bb_queue_empty", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
